// File: rtl/vend_ctrl_if.sv
// Coin-acceptor / dispenser signal bundle for the vending controller.
// The slave modport is the controller side, the master modport the acceptor/actuator side.
interface vend_ctrl_if #(
  parameter int CREDIT_W = 4
);
  logic                coin_valid;
  logic [1:0]          coin_val;
  logic                cancel;
  logic [1:0]          state;
  logic [CREDIT_W-1:0] credit;
  logic                vend_out;
  logic                change_pulse;
  logic                coin_reject;
  logic                busy;
  logic                timeout_out;

  modport master (
    output coin_valid, coin_val, cancel,
    input  state, credit, vend_out, change_pulse, coin_reject, busy, timeout_out
  );

  modport slave (
    input  coin_valid, coin_val, cancel,
    output state, credit, vend_out, change_pulse, coin_reject, busy, timeout_out
  );
endinterface

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: multi-denomination credit, vend, serial change and refund.
// Define VEND_CTRL_TIMEOUT_EN to add the inactivity refund timer (otherwise timeout_out stays 0).
module vend_ctrl #(
  parameter int PRICE       = 7,
  parameter int CREDIT_W    = 4,
  parameter int CHG_GAP     = 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  vend_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [3:0]        GAP_X   = 4'(CHG_GAP);

  if (PRICE < 1 || PRICE > 2**CREDIT_W - 6 || CHG_GAP < 0 || CHG_GAP > 15 || TIMEOUT_CYC < 2)
  begin : g_param_check
    $error("vend_ctrl: parameter out of range");
  end

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic [3:0]          gap_q, gap_d;
  logic                vend_q, vend_d;
  logic                pulse_q, pulse_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [CREDIT_W:0]   coin_units, sum;
  logic                timeout_hit, abort;

`ifdef VEND_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = (state_q == ACCUM) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Counts only uninterrupted ACCUM idling; any strobed coin or fresh entry restarts it.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ACCUM && state_d == ACCUM && !bus.coin_valid)
      to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    vend_d     = 1'b0;
    pulse_d    = 1'b0;
    reject_d   = 1'b0;
    timeout_d  = 1'b0;
    abort      = 1'b0;
    coin_units = '0;

    case (bus.coin_val)
      2'd0:    coin_units = (CREDIT_W+1)'(1);
      2'd1:    coin_units = (CREDIT_W+1)'(2);
      2'd2:    coin_units = (CREDIT_W+1)'(5);
      default: coin_units = '0;
    endcase
    sum = {1'b0, credit_q} + coin_units;

    case (state_q)
      IDLE, ACCUM: begin
        // Refund beats a simultaneous coin, which is handed back untouched.
        abort = (state_q == ACCUM) && (bus.cancel || timeout_hit) && (credit_q != '0);
        if (abort) begin
          rem_d     = credit_q;
          credit_d  = '0;
          gap_d     = '0;
          state_d   = CHANGE;
          pulse_d   = 1'b1;
          reject_d  = bus.coin_valid;
          timeout_d = timeout_hit;
        end else if (bus.coin_valid) begin
          if (bus.coin_val == 2'd3) begin
            reject_d = 1'b1;
          end else if (sum < PRICE_X) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = ACCUM;
          end else begin
            rem_d    = CREDIT_W'(sum - PRICE_X);
            credit_d = '0;
            state_d  = VEND;
            vend_d   = 1'b1;
          end
        end
      end

      VEND: begin
        reject_d = bus.coin_valid;
        gap_d    = '0;
        if (rem_q != '0) begin
          state_d = CHANGE;
          pulse_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      CHANGE: begin
        reject_d = bus.coin_valid;
        // gap_q == 0 marks a pulse cycle; 1..CHG_GAP count the silent cycles after it.
        if (gap_q == 4'd0) begin
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          if (CHG_GAP == 0) begin
            if (rem_q <= CREDIT_W'(1)) state_d = IDLE;
            else                       pulse_d = 1'b1;
          end else begin
            gap_d = 4'd1;
          end
        end else if (gap_q >= GAP_X) begin
          gap_d = 4'd0;
          if (rem_q == '0) state_d = IDLE;
          else             pulse_d = 1'b1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
        rem_d    = '0;
        gap_d    = '0;
      end
    endcase

    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      vend_q    <= 1'b0;
      pulse_q   <= 1'b0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      vend_q    <= vend_d;
      pulse_q   <= pulse_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.credit       = credit_q;
  assign bus.vend_out     = vend_q;
  assign bus.change_pulse = pulse_q;
  assign bus.coin_reject  = reject_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_out  = timeout_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Testbench for vend_ctrl: directed vector table, reset/hold corner sequences,
// and randomized traffic against an event-schedule reference model.
module tb_vend_ctrl;
  localparam int PRICE       = 7;
  localparam int CREDIT_W    = 4;
  localparam int CHG_GAP     = 1;
  localparam int TIMEOUT_CYC = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  vend_ctrl_if #(.CREDIT_W(CREDIT_W)) bus ();

  vend_ctrl #(
    .PRICE(PRICE), .CREDIT_W(CREDIT_W), .CHG_GAP(CHG_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [1:0] val;
    logic       can;
    logic [1:0] st;
    logic [3:0] cr;
    logic       vend;
    logic       pulse;
    logic       rej;
    logic       busy;
  } vec_t;

  // Future output cycles the machine is committed to (vend then change pulses and gaps).
  typedef struct packed {
    logic [1:0] st;
    logic       vend;
    logic       pulse;
  } ev_t;

  vec_t       vecs[32];
  ev_t        sched[$];
  int         m_credit;
  logic [1:0] m_state;
  logic [1:0] e_st;
  logic       e_v, e_p, e_r, e_b;
  logic       r_cv, r_can;
  logic [1:0] r_val;
  int         cnt_a, cnt_b;

  task automatic applyStimulus(input logic cv, input logic [1:0] val, input logic can);
    bus.coin_valid = cv;
    bus.coin_val   = val;
    bus.cancel     = can;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] st, input logic [3:0] cr,
                             input logic vend, input logic pulse, input logic rej, input logic busy);
    tests_run++;
    if (bus.state !== st || bus.credit !== cr || bus.vend_out !== vend || bus.change_pulse !== pulse ||
        bus.coin_reject !== rej || bus.busy !== busy || bus.timeout_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s: got st=%0d cr=%0d vend=%b pulse=%b rej=%b busy=%b to=%b, want st=%0d cr=%0d vend=%b pulse=%b rej=%b busy=%b to=0",
               name, bus.state, bus.credit, bus.vend_out, bus.change_pulse, bus.coin_reject, bus.busy,
               bus.timeout_out, st, cr, vend, pulse, rej, busy);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic doReset();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 2'd0;
    bus.cancel     = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    m_state  = 2'd0;
    m_credit = 0;
    sched.delete();
  endtask

  function automatic int unitsOf(input logic [1:0] val);
    if (val == 2'd0) return 1;
    if (val == 2'd1) return 2;
    return 5;
  endfunction

  function automatic void queueChange(input int n);
    for (int i = 0; i < n; i++) begin
      sched.push_back('{2'd3, 1'b0, 1'b1});
      for (int g = 0; g < CHG_GAP; g++) sched.push_back('{2'd3, 1'b0, 1'b0});
    end
  endfunction

  function automatic void modelStep(input logic cv, input logic [1:0] val, input logic can);
    ev_t ev;
    int  sum;
    ev  = '{m_state, 1'b0, 1'b0};
    e_r = 1'b0;
    if (m_state == 2'd2 || m_state == 2'd3) begin
      e_r = cv;
      if (sched.size() > 0) ev = sched.pop_front();
      else                  ev = '{2'd0, 1'b0, 1'b0};
    end else if (m_state == 2'd1 && can && m_credit > 0) begin
      e_r = cv;
      queueChange(m_credit);
      m_credit = 0;
      ev = sched.pop_front();
    end else if (cv && val == 2'd3) begin
      e_r = 1'b1;
    end else if (cv) begin
      sum = m_credit + unitsOf(val);
      if (sum < PRICE) begin
        m_credit = sum;
        ev = '{2'd1, 1'b0, 1'b0};
      end else begin
        m_credit = 0;
        sched.push_back('{2'd2, 1'b1, 1'b0});
        queueChange(sum - PRICE);
        ev = sched.pop_front();
      end
    end
    m_state = ev.st;
    e_st    = ev.st;
    e_v     = ev.vend;
    e_p     = ev.pulse;
    e_b     = (ev.st == 2'd2) || (ev.st == 2'd3);
  endfunction

  initial begin
    //          cv    val   can   st    cr    vend  pulse rej   busy
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 2'd1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 2'd1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 2'd0, 1'b0, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 2'd2, 1'b1, 2'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 2'd0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 2'd0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 2'd0, 1'b0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 2'd2, 1'b0, 2'd1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 2'd0, 1'b0, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[27] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 2'd1, 1'b0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[29] = '{1'b1, 2'd3, 1'b0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[30] = '{1'b1, 2'd2, 1'b0, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[31] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    doReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i].cv, vecs[i].val, vecs[i].can);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].cr, vecs[i].vend,
                  vecs[i].pulse, vecs[i].rej, vecs[i].busy);
    end

    // Asynchronous reset in the middle of a 3-unit change run.
    doReset();
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("pre_reset_change", 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1 checkOutput("async_reset", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0);
      if (bus.change_pulse) cnt_a++;
      if (bus.state != 2'd0) cnt_b++;
    end
    checkCount("post_reset_pulses", cnt_a, 0);
    checkCount("post_reset_not_idle", cnt_b, 0);

    // Without the timer, ACCUM must hold well past TIMEOUT_CYC; then refund by cancel.
    doReset();
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("hold_start", 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cnt_a = 0;
    for (int i = 0; i < TIMEOUT_CYC + 100; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0);
      if (bus.state != 2'd1 || bus.credit != 4'd2 || bus.timeout_out) cnt_a++;
    end
    checkCount("hold_accum_violations", cnt_a, 0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("cancel_refund", 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cnt_a = 1;
    cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0);
      if (bus.change_pulse) cnt_a++;
      if (bus.vend_out) cnt_b++;
    end
    checkCount("refund_pulses", cnt_a, 2);
    checkCount("refund_vends", cnt_b, 0);
    checkOutput("refund_done", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the schedule model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      r_cv  = 1'($urandom_range(0, 1));
      r_val = 2'($urandom_range(0, 3));
      r_can = ($urandom_range(0, 9) == 0);
      modelStep(r_cv, r_val, r_can);
      applyStimulus(r_cv, r_val, r_can);
      checkOutput($sformatf("rand%0d", n), e_st, 4'(m_credit), e_v, e_p, e_r, e_b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
